grid_tick_sequencer: RTL
========================

// Module: grid_tick_sequencer
// PURPOSE
//  Sequences one inference run on the core grid: streams host input packets into the grid's
//  west input of core 0, waits a programmed drain interval, then pulses the global tick.
//  Repeats for cfg_num_ticks ticks. Counts output spikes and latches grid errors.
//  Sits between the host packet FIFO (first-word-fall-through) and the grid top level.
// PARAMETERS
//  PACKET_WIDTH    30  grid packet width (dx+dy+axon+tick fields)
//  TICK_CNT_WIDTH  16  width of tick count config/counter
//  DRAIN_WIDTH     16  width of drain-interval config/counter
//  OUT_CNT_WIDTH   16  width of output-spike counter
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 async reset, active-low
//  start            in   1                 run request, sampled only in IDLE
//  abort            in   1                 return to IDLE, clears sticky error
//  cfg_num_ticks    in   TICK_CNT_WIDTH    ticks per run; 0 = run ignored
//  cfg_drain        in   DRAIN_WIDTH       idle cycles between last injection and tick
//  host_empty       in   1                 host FIFO empty
//  host_word        in   PACKET_WIDTH+2    {eot, pkt_valid, packet}, head of host FIFO
//  host_ren         out  1                 host FIFO pop
//  grid_ren         in   1                 grid ren_to_input_buffer
//  grid_empty       out  1                 to grid input_buffer_empty
//  grid_packet      out  PACKET_WIDTH      to grid packet_in
//  grid_tick        out  1                 to grid tick, one-cycle pulse
//  grid_out_valid   in   1                 grid packet_out_valid
//  grid_tc_err      in   1                 grid token_controller_error
//  grid_sch_err     in   1                 grid scheduler_error
//  busy             out  1                 high in INJECT/DRAIN/TICK
//  done             out  1                 one-cycle pulse at run completion
//  err              out  1                 sticky grid error flag
//  tick_idx         out  TICK_CNT_WIDTH    ticks issued this run
//  out_count        out  OUT_CNT_WIDTH     grid_out_valid cycles this run, saturating
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0 except grid_empty=1; counters 0.
//  States: IDLE, INJECT, DRAIN, TICK, ERROR.
//  IDLE: start=1 & cfg_num_ticks!=0 -> INJECT; latch cfgs; clear tick_idx, out_count.
//  INJECT: grid_packet = host_word[PACKET_WIDTH-1:0] (combinational).
//   grid_empty = host_empty | ~pkt_valid; forced 1 in every other state.
//   host_ren = ~host_empty & (pkt_valid ? grid_ren : 1) -- marker words (pkt_valid=0) are
//   consumed by this block in one cycle and never reach the grid.
//   Pop of a word with eot=1 -> DRAIN, drain counter loaded with latched cfg_drain.
//   Packet+eot in one word: packet delivered and state leaves INJECT in same pop.
//  DRAIN: counter decrements each cycle; at 0 -> TICK. cfg_drain=0: DRAIN lasts one cycle.
//  TICK: grid_tick=1 for exactly this cycle; tick_idx+1.
//   if tick_idx+1 == latched cfg_num_ticks -> IDLE with done=1 that cycle; else -> INJECT.
//  grid_tick latency: eot pop at cycle N -> tick at N+cfg_drain+2.
//  out_count increments on every grid_out_valid while busy; saturates at all-ones.
//  Errors: grid_tc_err|grid_sch_err while busy -> ERROR, err=1 sticky; ERROR drives no
//   pops, no ticks; leaves only on abort (-> IDLE, err cleared) or reset.
//  abort in any state -> IDLE next cycle, no done, counters hold; priority over error/start.
//  grid_ren with host_empty=1 or pkt_valid=0: no pop toward grid (empty masking).
//  start while busy or in ERROR: ignored; cfg changes mid-run ignored (latched).
// TESTING
//  cfg_num_ticks=1, cfg_drain=3, 2 packets (2nd eot), grid_ren each cycle -> 2 pops,
//   grid_tick exactly once 5 cycles after eot pop, done same cycle, tick_idx=1.
//  cfg_num_ticks=3, host words: marker eot x3 -> no grid reads (grid_empty=1),
//   3 tick pulses, done after third, out_count=0.
//  grid_ren held low 10 cycles with packet at head -> host_ren=0, no tick, busy=1.
//  grid_sch_err pulse in DRAIN -> err=1, no tick follows; abort -> IDLE, err=0.
//  grid_out_valid high 70000 cycles with OUT_CNT_WIDTH=16 -> out_count=65535.
//  rst asserted mid-INJECT -> grid_empty=1, grid_tick=0, busy=0 immediately, IDLE on release.

Source files
------------

// File: rtl/grid_tick_sequencer_if.sv
// Host-FIFO and grid-side signals of the tick sequencer.
// The slave modport is the sequencer; the master modport is the surrounding FIFO/grid.
interface grid_tick_sequencer_if #(
  parameter int PACKET_WIDTH = 30
);
  logic                    host_empty;
  logic [PACKET_WIDTH+1:0] host_word;
  logic                    host_ren;
  logic                    grid_ren;
  logic                    grid_empty;
  logic [PACKET_WIDTH-1:0] grid_packet;
  logic                    grid_tick;
  logic                    grid_out_valid;
  logic                    grid_tc_err;
  logic                    grid_sch_err;

  modport master (
    output host_empty, host_word, grid_ren, grid_out_valid, grid_tc_err, grid_sch_err,
    input  host_ren, grid_empty, grid_packet, grid_tick
  );

  modport slave (
    input  host_empty, host_word, grid_ren, grid_out_valid, grid_tc_err, grid_sch_err,
    output host_ren, grid_empty, grid_packet, grid_tick
  );
endinterface

// File: rtl/grid_tick_sequencer.sv
// Runs one inference on the core grid: inject host packets, wait the drain interval,
// pulse the global tick, repeat per configured tick count; counts spikes, latches errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start with a non-zero tick count
// S_INJECT | forwarding host words to the grid until an eot word pops
// S_DRAIN  | letting the grid settle for the latched drain interval
// S_TICK   | one-cycle global tick; run ends after the last one
// S_ERROR  | grid reported an error; parked until abort or reset
module grid_tick_sequencer #(
  parameter int PACKET_WIDTH   = 30,
  parameter int TICK_CNT_WIDTH = 16,
  parameter int DRAIN_WIDTH    = 16,
  parameter int OUT_CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [TICK_CNT_WIDTH-1:0] i_cfg_num_ticks,
  input  logic [DRAIN_WIDTH-1:0]    i_cfg_drain,
  grid_tick_sequencer_if.slave      bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [TICK_CNT_WIDTH-1:0] o_tick_idx,
  output logic [OUT_CNT_WIDTH-1:0]  o_out_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INJECT = 3'd1,
    S_DRAIN  = 3'd2,
    S_TICK   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TICK_CNT_WIDTH-1:0] r_num_ticks;
  logic [TICK_CNT_WIDTH-1:0] r_tick_idx;
  logic [DRAIN_WIDTH-1:0]    r_cfg_drain;
  logic [DRAIN_WIDTH-1:0]    r_drain_cnt;
  logic [OUT_CNT_WIDTH-1:0]  r_out_count;
  logic                      r_err;

  logic [TICK_CNT_WIDTH-1:0] w_tick_idx_inc;
  logic [PACKET_WIDTH-1:0]   w_grid_packet;
  logic                      w_eot;
  logic                      w_pkt_valid;
  logic                      w_grid_err;
  logic                      w_busy;
  logic                      w_start_ok;
  logic                      w_tick_last;
  logic                      w_host_ren;
  logic                      w_grid_empty;
  logic                      w_grid_tick;
  logic                      w_done;
  logic                      w_eot_pop;

  assign w_eot          = bus.host_word[PACKET_WIDTH+1];
  assign w_pkt_valid    = bus.host_word[PACKET_WIDTH];
  assign w_grid_err     = bus.grid_tc_err | bus.grid_sch_err;
  assign w_busy         = (r_state == S_INJECT) || (r_state == S_DRAIN) || (r_state == S_TICK);
  assign w_start_ok     = i_start && (i_cfg_num_ticks != '0);
  assign w_tick_idx_inc = r_tick_idx + TICK_CNT_WIDTH'(1);
  assign w_tick_last    = (w_tick_idx_inc == r_num_ticks);
  assign w_eot_pop      = w_host_ren && w_eot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_host_ren    = 1'b0;
    w_grid_empty  = 1'b1;
    w_grid_packet = '0;
    w_grid_tick   = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_INJECT;
        end
      end
      S_INJECT: begin
        // Marker words (pkt_valid=0) are swallowed here and never shown to the grid.
        w_grid_packet = bus.host_word[PACKET_WIDTH-1:0];
        w_grid_empty  = bus.host_empty | ~w_pkt_valid;
        w_host_ren    = ~bus.host_empty & (w_pkt_valid ? bus.grid_ren : 1'b1);
        if (w_eot_pop) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = S_TICK;
        end
      end
      S_TICK: begin
        w_grid_tick = 1'b1;
        if (w_tick_last) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = S_INJECT;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_busy && w_grid_err) begin
      w_state_nxt = S_ERROR;
      w_done      = 1'b0;
    end

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
      w_grid_tick = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_ticks <= '0;
      r_tick_idx  <= '0;
      r_cfg_drain <= '0;
      r_drain_cnt <= '0;
      r_out_count <= '0;
      r_err       <= 1'b0;
    end else begin
      if (i_abort) begin
        r_err <= 1'b0;
      end else if (w_busy && w_grid_err) begin
        r_err <= 1'b1;
      end

      // Abort freezes every counter in place for the host to inspect.
      if (!i_abort) begin
        if ((r_state == S_IDLE) && w_start_ok) begin
          r_num_ticks <= i_cfg_num_ticks;
          r_cfg_drain <= i_cfg_drain;
          r_tick_idx  <= '0;
          r_out_count <= '0;
        end

        if ((r_state == S_INJECT) && w_eot_pop) begin
          r_drain_cnt <= r_cfg_drain;
        end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
          r_drain_cnt <= r_drain_cnt - DRAIN_WIDTH'(1);
        end

        if (r_state == S_TICK) begin
          r_tick_idx <= w_tick_idx_inc;
        end

        if (w_busy && bus.grid_out_valid && (r_out_count != '1)) begin
          r_out_count <= r_out_count + OUT_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.host_ren    = w_host_ren;
  assign bus.grid_empty  = w_grid_empty;
  assign bus.grid_packet = w_grid_packet;
  assign bus.grid_tick   = w_grid_tick;

  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_err       = r_err;
  assign o_tick_idx  = r_tick_idx;
  assign o_out_count = r_out_count;

endmodule
